csoc_cmd_decoder: RTL and testbench
===================================

Name: csoc_cmd_decoder

Overview:
- Receive-side counterpart of the host command path. Consumes bytes from the host UART receiver (rx_data/new_rx_data), decodes 3-byte command frames and drives the CSoC test pins: clock, reset, scan enable, test mode, uart_read and data bus.
- Returns one response byte per frame over a valid/ready handshake to the host transmit path.
- Sits between the board UART and the CSoC pads; replaces free-running pin drive with host-controlled drive.

Parameters:
- TIMEOUT, 10000000: inter-byte timeout in clk cycles while a frame is partially received.
- CLK_HALF, 1: csoc_clk half-period in clk cycles (≥1) during clock-pulse commands.
- SYNC, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received host byte
- new_rx_data  in  1  one-cycle strobe, rx_data valid
- rsp_data  out  8  response byte to host transmitter
- rsp_valid  out  1  response pending; held until accepted
- rsp_ready  in  1  transmitter accepts rsp_data when rsp_valid&&rsp_ready
- csoc_clk  out  1  CSoC clock, low when idle
- csoc_rstn  out  1  CSoC reset (active-low)
- csoc_test_se  out  1  scan enable
- csoc_test_tm  out  1  test mode
- csoc_uart_read  out  1  CSoC uart_read pin
- csoc_data_o  out  8  data to CSoC
- csoc_data_i  in  8  data from CSoC
- busy  out  1  high in any state except IDLE
- err_timeout  out  1  sticky; set on frame timeout
- err_overrun  out  1  sticky; set when a byte is dropped

Behaviour:
- Reset (async, rstn=0): all outputs 0, state IDLE, counters 0. Sticky flags clear only on reset. Reset mid-command aborts immediately with no response.
- Frame format: SYNC, OPC, ARG.
- Opcodes:
  - 01: ctrl ← ARG[3:0]. Map: [0] csoc_rstn, [1] test_se, [2] test_tm, [3] uart_read. ARG[7:4] ignored.
  - 02: csoc_data_o ← ARG.
  - 03: emit ARG full csoc_clk pulses.
  - 04: sample csoc_data_i; ARG ignored.
  - any other: NAK.
- FSM states: IDLE, OPC, ARG, EXEC, CLKGEN, RESP.
  - IDLE: new_rx_data with rx_data==SYNC → OPC. Other bytes are discarded silently and are not an error.
  - OPC: next byte is latched as opcode → ARG.
  - ARG: next byte is latched as argument → EXEC.
  - EXEC (1 cycle): apply register write.
    - Ops 01/02/04 → RESP.
    - Op 03 with ARG≠0 → CLKGEN; with ARG=0 → RESP with ACK immediately.
    - Unknown opcode → RESP with NAK, and no pin changes.
  - CLKGEN: csoc_clk high for CLK_HALF cycles, then low for CLK_HALF cycles, per pulse. Down-counts ARG pulses; after the last low phase → RESP. csoc_clk is always low on leaving CLKGEN.
  - RESP: rsp_valid=1 with rsp_data stable until the handshake; then → IDLE the same cycle.
- Response values: ACK=8'h06 for ops 01/02/03. Op 04 returns the csoc_data_i value sampled in EXEC. NAK=8'h15.
- Pin timing: outputs registered; pin change visible the cycle after EXEC. Total latency from ARG strobe to rsp_valid: 2 cycles for ops 01/02/04.
- Timeout: in OPC or ARG, the counter resets on each new_rx_data. When it reaches TIMEOUT with no byte: → IDLE, err_timeout=1, no response.
- Overrun: new_rx_data in EXEC, CLKGEN or RESP → byte dropped, err_overrun=1. Current command is unaffected.
- A SYNC-valued byte in OPC/ARG is treated as data; there is no resync.
- Pulse counter is 8-bit, so max 255 pulses. Half-period counter width is $clog2(CLK_HALF+1).
- rsp_ready asserted outside RESP has no effect.

Decomposition:
- Shared package/header: opcode constants (OP_CTRL, OP_DATA, OP_CLK, OP_READ), ACK/NAK codes, SYNC default, state encodings.
- One natural sub-module: csoc_clk_pulser. Inputs: start, count[7:0], CLK_HALF. Outputs: csoc_clk, done. It owns the half-period and pulse counters.

Test Plan:
- Bytes A5 01 0B → csoc_rstn=1, se=1, tm=0, uart_read=1; rsp_data=06, rsp_valid held while rsp_ready=0 for 5 cycles, then one handshake.
- A5 03 05 with CLK_HALF=2 → exactly 5 csoc_clk pulses, each 2 cycles high / 2 cycles low; ACK 06 after the last falling edge; csoc_clk ends low.
- csoc_data_i=3C, bytes A5 04 00 → rsp_data=3C. Then A5 07 00 → rsp_data=15, and all pins unchanged.
- TIMEOUT=50: A5 01 then silence → IDLE after 50 cycles, err_timeout=1, no rsp_valid. Then a full A5 02 FF → csoc_data_o=FF, ACK 06.
- A5 03 0A, with byte 55 sent during CLKGEN → err_overrun=1; 10 pulses still complete; ACK 06. Leading garbage bytes 12 34 before A5 → ignored, no error.
- rstn pulled low mid-CLKGEN → all outputs 0 asynchronously. After release, A5 02 81 → csoc_data_o=81.

Source files
------------

// File: rtl/csoc_cmd_decoder_pkg.sv
// Shared constants and state encoding for the CSoC
// host command decoder.
package csoc_cmd_decoder_pkg;

  localparam logic [7:0] OP_CTRL  = 8'h01;
  localparam logic [7:0] OP_DATA  = 8'h02;
  localparam logic [7:0] OP_CLK   = 8'h03;
  localparam logic [7:0] OP_READ  = 8'h04;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] SYNC_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ARG,
    S_EXEC,
    S_CLKGEN,
    S_RESP
  } state_t;

endpackage

// File: rtl/csoc_cmd_decoder_clk_pulser.sv
// Emits a burst of full csoc_clk pulses, each CLK_HALF
// cycles high then CLK_HALF low; done pulses after the last.
module csoc_clk_pulser
  import csoc_cmd_decoder_pkg::*;
#(
  parameter int CLK_HALF = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] count,
  output logic       csoc_clk,
  output logic       done
);

  localparam int HW = $clog2(CLK_HALF + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_HALF - 1);

  logic          active;
  logic          clk_q;
  logic          done_q;
  logic [HW-1:0] hcnt;
  logic [7:0]    pcnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= 1'b0;
      clk_q  <= 1'b0;
      done_q <= 1'b0;
      hcnt   <= '0;
      pcnt   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        active <= (count != 8'd0);
        clk_q  <= (count != 8'd0);
        done_q <= (count == 8'd0);
        hcnt   <= '0;
        pcnt   <= count;
      end else if (active) begin
        if (hcnt == HLAST) begin
          hcnt <= '0;
          if (clk_q) begin
            clk_q <= 1'b0;
          end else if (pcnt == 8'd1) begin
            // last low phase ends: clock stays low
            active <= 1'b0;
            done_q <= 1'b1;
          end else begin
            pcnt  <= pcnt - 8'd1;
            clk_q <= 1'b1;
          end
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  assign csoc_clk = clk_q;
  assign done     = done_q;

endmodule

// File: rtl/csoc_cmd_decoder.sv
// Decodes 3-byte host frames (SYNC, OPC, ARG) into CSoC
// test pin drive and returns one response byte per frame.
module csoc_cmd_decoder
  import csoc_cmd_decoder_pkg::*;
#(
  parameter int          TIMEOUT  = 10000000,
  parameter int          CLK_HALF = 1,
  parameter logic [7:0]  SYNC     = SYNC_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic       csoc_uart_read,
  output logic [7:0] csoc_data_o,
  input  logic [7:0] csoc_data_i,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    opc_q;
  logic [7:0]    arg_q;
  logic [3:0]    ctrl_q;
  logic [7:0]    data_q;
  logic [7:0]    rsp_q;
  logic          err_to_q;
  logic          err_ov_q;
  logic [TW-1:0] tcnt;

  logic tmo;
  logic clk_done;
  logic is_clk_op;
  logic busy_c;
  logic valid_c;
  logic exec_c;
  logic start_c;
  logic wait_c;
  logic to_hit;
  logic ovr_hit;

  assign tmo       = (tcnt == TLAST);
  assign is_clk_op = (opc_q == OP_CLK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (new_rx_data && rx_data == SYNC)
          state_nxt = S_OPC;
      S_OPC:
        if (new_rx_data)  state_nxt = S_ARG;
        else if (tmo)     state_nxt = S_IDLE;
      S_ARG:
        if (new_rx_data)  state_nxt = S_EXEC;
        else if (tmo)     state_nxt = S_IDLE;
      S_EXEC:
        if (is_clk_op && arg_q != 8'd0)
          state_nxt = S_CLKGEN;
        else
          state_nxt = S_RESP;
      S_CLKGEN:
        if (clk_done) state_nxt = S_RESP;
      S_RESP:
        if (rsp_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = 1'b1;
    valid_c = 1'b0;
    exec_c  = 1'b0;
    start_c = 1'b0;
    wait_c  = 1'b0;
    ovr_hit = 1'b0;
    unique case (state)
      S_IDLE: busy_c = 1'b0;
      S_OPC,
      S_ARG:  wait_c = 1'b1;
      S_EXEC: begin
        exec_c  = 1'b1;
        start_c = is_clk_op && (arg_q != 8'd0);
        ovr_hit = new_rx_data;
      end
      S_CLKGEN: ovr_hit = new_rx_data;
      S_RESP: begin
        valid_c = 1'b1;
        ovr_hit = new_rx_data;
      end
      default: busy_c = 1'b0;
    endcase
    to_hit = wait_c && !new_rx_data && tmo;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
    end else if (wait_c && !new_rx_data && !tmo) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      tcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opc_q    <= '0;
      arg_q    <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      if (state == S_OPC && new_rx_data) opc_q <= rx_data;
      if (state == S_ARG && new_rx_data) arg_q <= rx_data;
      if (to_hit)  err_to_q <= 1'b1;
      if (ovr_hit) err_ov_q <= 1'b1;
      if (exec_c) begin
        unique case (1'b1)
          opc_q == OP_CTRL: begin
            ctrl_q <= arg_q[3:0];
            rsp_q  <= RSP_ACK;
          end
          opc_q == OP_DATA: begin
            data_q <= arg_q;
            rsp_q  <= RSP_ACK;
          end
          opc_q == OP_CLK:  rsp_q <= RSP_ACK;
          opc_q == OP_READ: rsp_q <= csoc_data_i;
          default:          rsp_q <= RSP_NAK;
        endcase
      end
    end
  end

  csoc_clk_pulser #(
    .CLK_HALF (CLK_HALF)
  ) u_pulser (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_c),
    .count    (arg_q),
    .csoc_clk (csoc_clk),
    .done     (clk_done)
  );

  assign busy           = busy_c;
  assign rsp_valid      = valid_c;
  assign rsp_data       = rsp_q;
  assign csoc_rstn      = ctrl_q[0];
  assign csoc_test_se   = ctrl_q[1];
  assign csoc_test_tm   = ctrl_q[2];
  assign csoc_uart_read = ctrl_q[3];
  assign csoc_data_o    = data_q;
  assign err_timeout    = err_to_q;
  assign err_overrun    = err_ov_q;

endmodule

// File: tb/tb_csoc_cmd_decoder.sv
// Self-checking bench for csoc_cmd_decoder: vector table,
// response scoreboard and multi-cycle corner sequences.
module tb_csoc_cmd_decoder;

  localparam int CH  = 2;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       csoc_clk;
  logic       csoc_rstn;
  logic       csoc_test_se;
  logic       csoc_test_tm;
  logic       csoc_uart_read;
  logic [7:0] csoc_data_o;
  logic [7:0] csoc_data_i;
  logic       busy;
  logic       err_timeout;
  logic       err_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  int rises = 0;
  int bad_runs = 0;
  int run = 0;
  logic prev_cc = 1'b0;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] arg;
    logic [7:0] din;
    logic [7:0] rsp;
    logic [3:0] pins;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[10];

  csoc_cmd_decoder #(
    .TIMEOUT  (TMO),
    .CLK_HALF (CH),
    .SYNC     (8'hA5)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .rx_data        (rx_data),
    .new_rx_data    (new_rx_data),
    .rsp_data       (rsp_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .csoc_clk       (csoc_clk),
    .csoc_rstn      (csoc_rstn),
    .csoc_test_se   (csoc_test_se),
    .csoc_test_tm   (csoc_test_tm),
    .csoc_uart_read (csoc_uart_read),
    .csoc_data_o    (csoc_data_o),
    .csoc_data_i    (csoc_data_i),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_overrun    (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [3:0] pins();
    return {csoc_uart_read, csoc_test_tm,
            csoc_test_se, csoc_rstn};
  endfunction

  // response scoreboard
  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %0h expected none",
                 rsp_data);
      end else begin
        check("rsp_data", {24'd0, rsp_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  // csoc_clk pulse shape monitor
  always @(negedge clk) begin
    if (csoc_clk !== prev_cc) begin
      if (prev_cc) begin
        if (run != CH) bad_runs++;
      end else begin
        if (rises > 0 && run != CH) bad_runs++;
        rises++;
      end
      run = 1;
    end else begin
      run++;
    end
    prev_cc = csoc_clk;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data     = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    new_rx_data = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc,
                            input logic [7:0] arg);
    send_byte(8'hA5);
    send_byte(opc);
    send_byte(arg);
  endtask

  task automatic wait_rsp(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_arrived", sb.size(), 0);
    sb.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{8'h02, 8'h5A, 8'h00, 8'h06, 4'hB, 8'h5A};
    tbl[1] = '{8'h04, 8'h00, 8'h3C, 8'h3C, 4'hB, 8'h5A};
    tbl[2] = '{8'h07, 8'h00, 8'h00, 8'h15, 4'hB, 8'h5A};
    tbl[3] = '{8'h01, 8'hF4, 8'h00, 8'h06, 4'h4, 8'h5A};
    tbl[4] = '{8'h03, 8'h00, 8'h00, 8'h06, 4'h4, 8'h5A};
    tbl[5] = '{8'h00, 8'h12, 8'h00, 8'h15, 4'h4, 8'h5A};
    tbl[6] = '{8'h02, 8'hA5, 8'h00, 8'h06, 4'h4, 8'hA5};
    tbl[7] = '{8'hA5, 8'h02, 8'h00, 8'h15, 4'h4, 8'hA5};
    tbl[8] = '{8'h04, 8'h99, 8'hC3, 8'hC3, 4'h4, 8'hA5};
    tbl[9] = '{8'h01, 8'h0F, 8'h00, 8'h06, 4'hF, 8'hA5};

    rstn        = 1'b0;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    rsp_ready   = 1'b1;
    csoc_data_i = 8'h00;
    #23;
    check("reset_pins",
          {csoc_clk, pins(), busy, rsp_valid,
           err_timeout, err_overrun}, 0);
    check("reset_bytes", {csoc_data_o, rsp_data}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycles(2);

    // ctrl write with a stalled transmitter
    rsp_ready = 1'b0;
    sb.push_back(8'h06);
    send_frame(8'h01, 8'h0B);
    check("latency_exec", rsp_valid, 0);
    @(posedge clk);
    #1;
    check("ctrl_pins", pins(), 4'hB);
    for (int i = 0; i < 5; i++) begin
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_data", rsp_data, 8'h06);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_rsp(10);
    check("one_handshake", rsp_valid, 0);

    for (int i = 0; i < 10; i++) begin
      csoc_data_i = tbl[i].din;
      rises = 0;
      sb.push_back(tbl[i].rsp);
      send_frame(tbl[i].opc, tbl[i].arg);
      wait_rsp(20);
      check("vec_pins", pins(), tbl[i].pins);
      check("vec_dout", csoc_data_o, tbl[i].dout);
      check("vec_no_clk", rises, 0);
    end

    // 5 pulses, CH high / CH low each
    rises = 0;
    bad_runs = 0;
    sb.push_back(8'h06);
    send_frame(8'h03, 8'h05);
    wait_rsp(100);
    check("clk5_rises", rises, 5);
    check("clk5_shape", bad_runs, 0);
    check("clk5_low_end", csoc_clk, 0);
    check("clk5_pins", pins(), 4'hF);

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    cycles(TMO - 5);
    check("tmo_still_busy", busy, 1);
    check("tmo_not_yet", err_timeout, 0);
    cycles(10);
    check("tmo_idle", busy, 0);
    check("tmo_flag", err_timeout, 1);
    check("tmo_pins", pins(), 4'hF);
    sb.push_back(8'h06);
    send_frame(8'h02, 8'hFF);
    wait_rsp(20);
    check("after_tmo_dout", csoc_data_o, 8'hFF);
    check("tmo_sticky", err_timeout, 1);

    // leading garbage, then overrun during pulses
    send_byte(8'h12);
    send_byte(8'h34);
    cycles(2);
    check("garbage_idle", busy, 0);
    check("garbage_no_ovr", err_overrun, 0);
    rises = 0;
    bad_runs = 0;
    sb.push_back(8'h06);
    send_frame(8'h03, 8'h0A);
    cycles(6);
    send_byte(8'h55);
    check("ovr_flag", err_overrun, 1);
    wait_rsp(200);
    check("ovr_rises", rises, 10);
    check("ovr_shape", bad_runs, 0);
    check("ovr_dout", csoc_data_o, 8'hFF);
    cycles(3);
    check("ovr_idle", busy, 0);

    // asynchronous reset in the middle of a pulse burst
    sb.push_back(8'h06);
    send_frame(8'h03, 8'h0A);
    begin
      int n = 0;
      while (csoc_clk !== 1'b1 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("clk_high_seen", csoc_clk, 1);
    end
    #2;
    rstn = 1'b0;
    #1;
    sb.delete();
    check("arst_pins",
          {csoc_clk, pins(), busy, rsp_valid,
           err_timeout, err_overrun}, 0);
    check("arst_bytes", {csoc_data_o, rsp_data}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycles(2);
    sb.push_back(8'h06);
    send_frame(8'h02, 8'h81);
    wait_rsp(20);
    check("post_rst_dout", csoc_data_o, 8'h81);
    check("post_rst_pins", pins(), 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
